// File: rtl/key_pkg.sv
// Shared types and constants for the key loader: FSM state encoding, default sizing and the parity helper.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARMED = 3'd3,
        ST_ERR   = 3'd4
    } key_state_t;

    localparam int KEY_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF   = 16;

    // Even-parity bit: the value that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/key_loader_if.sv
// Key-provisioning bus: serial load handshake plus the key presented to the locked FSM.
interface key_loader_if
    import key_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEF
);
    logic                 key_start;
    logic                 key_bit;
    logic                 key_bit_valid;
    logic                 key_bit_ready;
    logic [KEY_WIDTH-1:0] keyinput;
    logic                 key_valid;
    logic                 key_err;
    logic                 busy;

    modport master (
        output key_start, key_bit, key_bit_valid,
        input  key_bit_ready, keyinput, key_valid, key_err, busy
    );

    modport slave (
        input  key_start, key_bit, key_bit_valid,
        output key_bit_ready, keyinput, key_valid, key_err, busy
    );
endinterface

// File: rtl/key_shift_reg.sv
// Serial-in/parallel-out key register: writes din at bit position idx; indices beyond the key are ignored.
module key_shift_reg #(
    parameter int KEY_WIDTH = 8,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 din,
    output logic [KEY_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (idx == IDX_W'(i)) q[i] <= din;
            end
        end
    end

endmodule

// File: rtl/key_loader.sv
// Write-once serial key loader feeding the locked FSM keyinput bus.
// Optional even-parity trailer bit enabled by defining KEY_LOADER_PARITY_EN.
module key_loader
    import key_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    key_loader_if.slave  bus
);

`ifdef KEY_LOADER_PARITY_EN
    localparam int NBITS = KEY_WIDTH + 1;
`else
    localparam int NBITS = KEY_WIDTH;
`endif
    localparam int CNT_W  = $clog2(NBITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    key_state_t           state, state_nxt;
    logic [CNT_W-1:0]     bitcnt;
    logic [IDLE_W-1:0]    idlecnt;
    logic [KEY_WIDTH-1:0] key_q;
    logic [KEY_WIDTH-1:0] key_reg;
    logic                 accept;
    logic                 start_load;
    logic                 last_bit;
    logic                 timed_out;
    logic                 check_ok;

    always_comb begin
        accept     = (state == ST_LOAD) && bus.key_bit_valid;
        start_load = (state == ST_IDLE) && bus.key_start;
        last_bit   = accept && (bitcnt == CNT_W'(NBITS - 1));
        // An accept in the same cycle always beats the timeout.
        timed_out  = (state == ST_LOAD) && !accept && (idlecnt == IDLE_W'(TIMEOUT - 1));
    end

`ifdef KEY_LOADER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (start_load) begin
            parity_q <= 1'b0;
        end else if (accept && (bitcnt == CNT_W'(KEY_WIDTH))) begin
            parity_q <= bus.key_bit;
        end
    end

    assign check_ok = (even_parity(32'(key_q)) == parity_q);
`else
    assign check_ok = 1'b1;
`endif

    key_shift_reg #(
        .KEY_WIDTH (KEY_WIDTH),
        .IDX_W     (CNT_W)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .clr (start_load),
        .en  (accept),
        .idx (bitcnt),
        .din (bus.key_bit),
        .q   (key_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_load) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (last_bit)       state_nxt = ST_CHECK;
                else if (timed_out) state_nxt = ST_ERR;
            end
            ST_CHECK: state_nxt = check_ok ? ST_ARMED : ST_ERR;
            ST_ARMED: state_nxt = ST_ARMED;
            ST_ERR:   state_nxt = ST_ERR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter never wraps (load ends at NBITS); idle counter saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt  <= '0;
            idlecnt <= '0;
        end else if (start_load) begin
            bitcnt  <= '0;
            idlecnt <= '0;
        end else if (accept) begin
            bitcnt  <= bitcnt + CNT_W'(1);
            idlecnt <= '0;
        end else if ((state == ST_LOAD) && (idlecnt != IDLE_W'(TIMEOUT))) begin
            idlecnt <= idlecnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg <= '0;
        end else if ((state == ST_CHECK) && (state_nxt == ST_ARMED)) begin
            key_reg <= key_q;
        end
    end

    assign bus.keyinput      = (state == ST_ARMED) ? key_reg : '0;
    assign bus.key_valid     = (state == ST_ARMED);
    assign bus.key_err       = (state == ST_ERR);
    assign bus.key_bit_ready = (state == ST_LOAD);
    assign bus.busy          = (state == ST_LOAD) || (state == ST_CHECK);

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader; parity vectors run only when KEY_LOADER_PARITY_EN is defined.
module tb_key_loader;

`ifdef KEY_LOADER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   fails;
    int   rdy;

    key_loader_if #(.KEY_WIDTH(8)) bus ();

    key_loader #(
        .KEY_WIDTH (8),
        .TIMEOUT   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.key_start = 1'b1;
        step();
        bus.key_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Sends nbits bits LSB first (bit 8 is the parity bit), gap idle cycles between bits.
    task automatic send_key(input logic [7:0] k, input int nbits, input int gap,
                            input logic par, output int ready_cnt);
        ready_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.key_bit_valid = 1'b1;
            bus.key_bit       = (i < 8) ? k[i] : par;
            if (bus.key_bit_ready) ready_cnt++;
            step();
            bus.key_bit_valid = 1'b0;
            bus.key_bit       = 1'b0;
            if (i < nbits - 1) repeat (gap) step();
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        rst    = 1'b0;
        bus.key_start     = 1'b0;
        bus.key_bit       = 1'b0;
        bus.key_bit_valid = 1'b0;

        repeat (3) step();
        chk("rst_keyinput", 32'(bus.keyinput), 32'h00);
        chk("rst_key_valid", 32'(bus.key_valid), 0);
        chk("rst_ready", 32'(bus.key_bit_ready), 0);
        chk("rst_key_err", 32'(bus.key_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);

        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (c % 10 == 9) begin
                chk("idle_keyinput", 32'(bus.keyinput), 32'h00);
                chk("idle_key_valid", 32'(bus.key_valid), 0);
                chk("idle_ready", 32'(bus.key_bit_ready), 0);
            end
        end

        // Start coincides with a valid bit in IDLE: that bit must not be captured.
        bus.key_start     = 1'b1;
        bus.key_bit_valid = 1'b1;
        bus.key_bit       = 1'b0;
        step();
        bus.key_start     = 1'b0;
        bus.key_bit_valid = 1'b0;
        chk("load_busy", 32'(bus.busy), 1);
        chk("load_ready", 32'(bus.key_bit_ready), 1);
        send_key(8'hA5, NB, 0, ^8'hA5, rdy);
        chk("a5_ready_cycles", 32'(rdy), 32'(NB));
        chk("check_busy", 32'(bus.busy), 1);
        chk("check_ready", 32'(bus.key_bit_ready), 0);
        chk("check_key_valid", 32'(bus.key_valid), 0);
        chk("check_keyinput", 32'(bus.keyinput), 32'h00);
        step();
        chk("a5_keyinput", 32'(bus.keyinput), 32'hA5);
        chk("a5_key_valid", 32'(bus.key_valid), 1);
        chk("a5_busy", 32'(bus.busy), 0);
        chk("a5_ready", 32'(bus.key_bit_ready), 0);

        do_reset();
        chk("rst2_keyinput", 32'(bus.keyinput), 32'h00);
        pulse_start();
        send_key(8'h3C, NB, 3, ^8'h3C, rdy);
        step();
        chk("3c_keyinput", 32'(bus.keyinput), 32'h3C);
        chk("3c_key_valid", 32'(bus.key_valid), 1);
        pulse_start();
        send_key(8'hFF, NB, 0, 1'b0, rdy);
        repeat (3) step();
        chk("armed_ready_cycles", 32'(rdy), 0);
        chk("armed_keyinput", 32'(bus.keyinput), 32'h3C);
        chk("armed_key_valid", 32'(bus.key_valid), 1);

        do_reset();
        pulse_start();
        send_key(8'h07, 3, 0, 1'b0, rdy);
        repeat (15) step();
        chk("to_15_err", 32'(bus.key_err), 0);
        chk("to_15_busy", 32'(bus.busy), 1);
        step();
        chk("to_err", 32'(bus.key_err), 1);
        chk("to_keyinput", 32'(bus.keyinput), 32'h00);
        chk("to_key_valid", 32'(bus.key_valid), 0);
        chk("to_busy", 32'(bus.busy), 0);
        pulse_start();
        repeat (4) step();
        chk("err_sticky", 32'(bus.key_err), 1);
        chk("err_ready", 32'(bus.key_bit_ready), 0);
        chk("err_keyinput", 32'(bus.keyinput), 32'h00);

        // Accept on the cycle the idle counter would expire keeps the load alive.
        do_reset();
        pulse_start();
        repeat (15) step();
        send_key(8'hFF, 5, 0, 1'b0, rdy);
        chk("edge_accept_err", 32'(bus.key_err), 0);
        chk("edge_accept_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("midrst_keyinput", 32'(bus.keyinput), 32'h00);
        chk("midrst_busy", 32'(bus.busy), 0);
        step();
        rst = 1'b1;
        step();
        pulse_start();
        send_key(8'h5A, NB, 0, ^8'h5A, rdy);
        step();
        chk("5a_keyinput", 32'(bus.keyinput), 32'h5A);
        chk("5a_key_valid", 32'(bus.key_valid), 1);

`ifdef KEY_LOADER_PARITY_EN
        do_reset();
        pulse_start();
        send_key(8'h01, NB, 0, 1'b1, rdy);
        step();
        chk("par_ok_keyinput", 32'(bus.keyinput), 32'h01);
        chk("par_ok_valid", 32'(bus.key_valid), 1);
        do_reset();
        pulse_start();
        send_key(8'h01, NB, 0, 1'b0, rdy);
        step();
        chk("par_bad_err", 32'(bus.key_err), 1);
        chk("par_bad_keyinput", 32'(bus.keyinput), 32'h00);
        chk("par_bad_valid", 32'(bus.key_valid), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Upstream key-provisioning stage for the locked FSM benchmarks. Drives the keyinput bus that selects real vs. dummy state transitions.
- Accepts a key serially over a valid/ready handshake and holds it write-once.
- Presents the key to the locked FSM only after a complete, well-formed load. Until then, and after any error, keyinput is all zeros, which steers the locked FSM into its dummy (_d) states.

Parameters:
- KEY_WIDTH, 8, number of key bits delivered to the locked FSM (1..32).
- TIMEOUT, 16, max idle cycles between accepted bits during a load before abort (>=2).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- key_start  input  1  one-cycle pulse; begins a load when in IDLE.
- key_bit  input  1  serial key data, LSB first.
- key_bit_valid  input  1  key_bit is valid this cycle.
- key_bit_ready  output  1  loader accepts a bit this cycle.
- keyinput  output  KEY_WIDTH  key to locked FSM; zeros unless ARMED.
- key_valid  output  1  high while ARMED.
- key_err  output  1  high while in ERR (sticky until reset).
- busy  output  1  high in LOAD or CHECK.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift register=0, bit counter=0, idle counter=0.
  - All outputs 0: keyinput=0, key_valid=0, key_err=0, key_bit_ready=0, busy=0.
- States: IDLE, LOAD, CHECK, ARMED, ERR. Encoding is in the package.
- IDLE:
  - key_start=1 → LOAD; clear the shift register and both counters.
  - key_bit_valid is ignored.
- LOAD:
  - key_bit_ready=1 (combinational from state) and busy=1.
  - Accept a bit when key_bit_valid && key_bit_ready: shift it in at bit [bitcnt], increment bitcnt, clear idle counter.
  - No accept: idle counter increments. When it reaches TIMEOUT → ERR.
  - Accepting bit KEY_WIDTH-1 → CHECK on the next edge.
  - key_start during LOAD is ignored, not a restart.
- CHECK:
  - One cycle, busy=1, key_bit_ready=0.
  - Without the optional feature → ARMED unconditionally.
- ARMED:
  - keyinput = registered key, key_valid=1.
  - Write-once: key_start and key_bit_valid are ignored until reset.
- ERR:
  - keyinput=0, key_err=1, key_valid=0, key_bit_ready=0.
  - Only reset exits ERR.
- Latency: keyinput/key_valid go valid 2 clk edges after the final accepted bit (LOAD→CHECK, CHECK→ARMED).
- keyinput is registered and glitch-free. It updates only on the CHECK→ARMED edge and is forced to zero by reset.
- Counters:
  - bitcnt width = clog2(KEY_WIDTH+1); it never wraps within a load.
  - The idle counter saturates at TIMEOUT.
- Simultaneous events:
  - key_start and key_bit_valid in the same IDLE cycle: start only; that bit is not captured.
  - Timeout and accept in the same cycle: the accept wins and the idle counter clears.
- Reset mid-LOAD: the partial key is discarded and keyinput stays 0.

Optional Feature:
- Macro KEY_LOADER_PARITY_EN.
- Defined:
  - LOAD expects KEY_WIDTH+1 bits; the last is an even-parity bit over the key.
  - CHECK compares it: match → ARMED; mismatch → ERR with keyinput held 0.
  - The total accepted-bit count becomes KEY_WIDTH+1.
- Undefined: no parity bit, and CHECK always → ARMED.

Decomposition:
- Shared package key_pkg holds:
  - the state enum typedef (IDLE, LOAD, CHECK, ARMED, ERR);
  - the default KEY_WIDTH/TIMEOUT constants;
  - a parity function.
- One natural sub-module, key_shift_reg: a KEY_WIDTH serial-in/parallel-out register with clear, shift-enable and bit index. The top keeps the FSM and the counters.

Test Plan:
- Reset held low, then released with no start → keyinput=8'h00, key_valid=0, key_bit_ready=0 for 50 cycles.
- key_start, then 8 back-to-back bits for 0xA5, LSB first → key_bit_ready high for 8 cycles; keyinput=8'hA5 and key_valid=1 two edges after the last bit.
- Load 0x3C with 3-cycle gaps between bits (below TIMEOUT=16) → ARMED with keyinput=8'h3C. A second key_start with 0xFF bits afterwards → keyinput still 8'h3C.
- key_start, 3 bits, then valid low for 16 cycles → key_err=1, keyinput=0. key_start after that → no change until rst.
- With KEY_LOADER_PARITY_EN: key 0x01 + parity 1 → ARMED 8'h01; key 0x01 + parity 0 → key_err=1, keyinput=0.
- rst asserted after 5 of 8 bits, then a full reload of 0x5A → keyinput=8'h5A with no residue from the partial load.
